// File: rtl/mem_tile_reader_pkg.sv
// Shared memory-bus types plus the tile reader's state and reorder-slot definitions.
// Bus widths: 32-bit line address, 64-bit line, 4-bit transaction tag (0 means none).
package mem_tile_reader_pkg;

  localparam int ADDR_W  = 32;
  localparam int BLOCK_W = 64;
  localparam int TAG_W   = 4;

  typedef logic [ADDR_W-1:0]  ADDR;
  typedef logic [BLOCK_W-1:0] MEM_BLOCK;
  typedef logic [TAG_W-1:0]   MEM_TAG;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'h0,
    MEM_LOAD  = 2'h1,
    MEM_STORE = 2'h2
  } MEM_COMMAND;

  typedef enum logic [1:0] {
    IDLE  = 2'h0,
    ISSUE = 2'h1,
    WAIT  = 2'h2,
    FIN   = 2'h3
  } TILE_RD_STATE;

  typedef struct packed {
    logic     pending;
    logic     filled;
    MEM_TAG   tag;
    MEM_BLOCK data;
  } TILE_ROB_ENTRY;

endpackage

// File: rtl/mem_tile_reader_rob.sv
// tile_rob: reorder slots with tag CAM on the return path and a registered head-slot view.
// A return is visible on head_vld one cycle later; a drained slot is free from the next cycle.
module tile_rob
  import mem_tile_reader_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alloc_en,
  input  logic [$clog2(DEPTH)-1:0] alloc_idx,
  input  MEM_TAG                   alloc_tag,
  input  MEM_TAG                   ret_tag,
  input  MEM_BLOCK                 ret_data,
  input  logic                     drain_en,
  input  logic [$clog2(DEPTH)-1:0] head_idx,
  output logic                     head_vld,
  output MEM_BLOCK                 head_data
);

  TILE_ROB_ENTRY slot_q [DEPTH];
  TILE_ROB_ENTRY slot_d [DEPTH];

  always_comb begin
    slot_d = slot_q;
    // Tags from other requesters match nothing here and simply fall through.
    for (int i = 0; i < DEPTH; i++) begin
      if ((ret_tag != '0) && slot_q[i].pending && !slot_q[i].filled &&
          (slot_q[i].tag == ret_tag)) begin
        slot_d[i].pending = 1'b0;
        slot_d[i].filled  = 1'b1;
        slot_d[i].data    = ret_data;
      end
    end
    if (drain_en) begin
      slot_d[head_idx] = '0;
    end
    if (alloc_en) begin
      slot_d[alloc_idx] = '{pending: 1'b1, filled: 1'b0, tag: alloc_tag, data: '0};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        slot_q[i] <= '0;
      end
    end else begin
      slot_q <= slot_d;
    end
  end

  assign head_vld  = slot_q[head_idx].filled;
  assign head_data = slot_q[head_idx].data;

endmodule

// File: rtl/mem_tile_reader.sv
// mem_tile_reader: one MEM_LOAD per 64-bit line, returns reordered and streamed in address order.
// First load the cycle after start; return-to-out_valid 1 cycle; out_ready low stalls issue at ROB_DEPTH outstanding.
module mem_tile_reader
  import mem_tile_reader_pkg::*;
#(
  parameter int LINES_MAX = 64,
  parameter int ROB_DEPTH = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  ADDR                            base_addr,
  input  logic [$clog2(LINES_MAX+1)-1:0] num_lines,
  input  logic                           bus_grant,
  output MEM_COMMAND                     proc2mem_command,
  output ADDR                            proc2mem_addr,
  output MEM_BLOCK                       proc2mem_data,
  input  MEM_TAG                         mem2proc_transaction_tag,
  input  MEM_BLOCK                       mem2proc_data,
  input  MEM_TAG                         mem2proc_data_tag,
  output logic                           out_valid,
  input  logic                           out_ready,
  output MEM_BLOCK                       out_data,
  output logic                           out_last,
  output logic                           busy,
  output logic                           done
);

  localparam int          CW      = $clog2(LINES_MAX + 1);
  localparam int          IW      = $clog2(ROB_DEPTH);
  localparam logic [CW:0] ROB_LIM = (CW + 1)'(ROB_DEPTH);

  TILE_RD_STATE  state_q, state_d;
  ADDR           base_q, base_d;
  logic [CW-1:0] num_q, num_d;
  logic [CW-1:0] issue_q, issue_d;
  logic [CW-1:0] drain_q, drain_d;
  logic [CW-1:0] inflight, last_idx;
  logic          issue_ok, accept, beat_fire, head_vld;

  assign inflight = issue_q - drain_q;
  assign last_idx = num_q - CW'(1);

  // Occupancy uses registered counters, so a slot drained this cycle is reusable only next cycle.
  assign issue_ok  = (state_q == ISSUE) && bus_grant &&
                     ({1'b0, inflight} < ROB_LIM) && (issue_q < num_q);
  assign accept    = issue_ok && (mem2proc_transaction_tag != '0);
  assign beat_fire = out_valid && out_ready;

  assign proc2mem_command = issue_ok ? MEM_LOAD : MEM_NONE;
  assign proc2mem_addr    = issue_ok ? (base_q + {{(ADDR_W-CW-3){1'b0}}, issue_q, 3'b000}) : '0;
  assign proc2mem_data    = '0;

  assign out_valid = head_vld;
  assign out_last  = head_vld && (drain_q == last_idx);
  assign busy      = (state_q == ISSUE) || (state_q == WAIT);
  assign done      = (state_q == FIN);

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    num_d   = num_q;
    issue_d = issue_q;
    drain_d = drain_q;
    if (accept) begin
      issue_d = issue_q + CW'(1);
    end
    if (beat_fire) begin
      drain_d = drain_q + CW'(1);
    end
    case (state_q)
      IDLE: begin
        if (start) begin
          if (num_lines == '0) begin
            state_d = FIN;
          end else begin
            base_d  = {base_addr[ADDR_W-1:3], 3'b000};
            num_d   = num_lines;
            issue_d = '0;
            drain_d = '0;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (accept && (issue_q == last_idx)) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (beat_fire && (drain_q == last_idx)) begin
          state_d = FIN;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      base_q  <= '0;
      num_q   <= '0;
      issue_q <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      num_q   <= num_d;
      issue_q <= issue_d;
      drain_q <= drain_d;
    end
  end

  tile_rob #(
    .DEPTH(ROB_DEPTH)
  ) u_rob (
    .clk       (clk),
    .rst       (rst),
    .alloc_en  (accept),
    .alloc_idx (issue_q[IW-1:0]),
    .alloc_tag (mem2proc_transaction_tag),
    .ret_tag   (mem2proc_data_tag),
    .ret_data  (mem2proc_data),
    .drain_en  (beat_fire),
    .head_idx  (drain_q[IW-1:0]),
    .head_vld  (head_vld),
    .head_data (out_data)
  );

endmodule

// File: doc/mem_tile_reader.md
# mem_tile_reader

Bulk-read engine on the accelerator side of the unified memory bus. Given a base address and a line count, it issues one `MEM_LOAD` per 64-bit line, tracks outstanding transaction tags, and reorders returned data. It delivers the lines in ascending address order on a valid/ready stream. It is the initiator for the `mem` responder interface and feeds the Q/K/V tile buffers inside `AURA`.

## Interface
Parameters:
- `LINES_MAX`, 64: maximum lines per request; sets the `num_lines` width as $clog2(LINES_MAX+1).
- `ROB_DEPTH`, 8: number of reorder slots, which is also the outstanding-load limit. Must be a power of 2.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `start`  in  1: pulse that launches a read. Ignored while `busy`.
- `base_addr`  in  ADDR: first line address. 8-byte aligned, and bits [2:0] are ignored.
- `num_lines`  in  $clog2(LINES_MAX+1): number of lines, from 0 to LINES_MAX.
- `bus_grant`  in  1: arbiter grant. Commands are driven only when this is high.
- `proc2mem_command`  out  MEM_COMMAND: `MEM_LOAD` or `MEM_NONE`.
- `proc2mem_addr`  out  ADDR: load address.
- `proc2mem_data`  out  MEM_BLOCK: tied to 0.
- `mem2proc_transaction_tag`  in  MEM_TAG: nonzero means the request was accepted this cycle; 0 means rejected.
- `mem2proc_data`  in  MEM_BLOCK: returned line.
- `mem2proc_data_tag`  in  MEM_TAG: nonzero marks valid return data for that tag.
- `out_valid` / `out_ready`  out / in  1: stream handshake.
- `out_data`  out  MEM_BLOCK: line data.
- `out_last`  out  1: marks the final line.
- `busy`  out  1: high from the cycle after `start` until `done`.
- `done`  out  1: one-cycle pulse.

## Operation
State machine: `IDLE`, `ISSUE`, `WAIT`, `FIN`.
- `IDLE`
  - On `start` with `num_lines`=0: go to `FIN`. No loads are issued.
  - On `start` with `num_lines`>0: latch `base_addr` and `num_lines`, clear the counters, go to `ISSUE`.
- `ISSUE`
  - Drive `MEM_LOAD` at `base + 8*issue_idx` when all of these hold: `bus_grant`=1, (`issue_idx` − `drain_idx`) < ROB_DEPTH, and `issue_idx` < `num_lines`. Otherwise drive `MEM_NONE` and addr 0.
  - Acceptance means a load was driven and `mem2proc_transaction_tag`≠0. On acceptance, write slot `issue_idx % ROB_DEPTH` as {pending=1, tag, filled=0} and increment `issue_idx`.
  - On rejection (tag 0), retry the same address on the next eligible cycle. No address is ever skipped.
  - When the last line is accepted, go to `WAIT`.
- `WAIT`
  - Go to `FIN` in the cycle the last beat handshakes.
- `FIN`
  - Assert `done` for one cycle and go to `IDLE`.
- Return path, active in all states:
  - If `mem2proc_data_tag`≠0, CAM-match it against pending, unfilled slots.
  - On a match, store the data, set filled, and clear pending.
  - On no match (another requester's tag), ignore the return.
  - At most one slot matches, because memory never reuses an outstanding tag.
- Drain path:
  - `out_valid` = the head slot (`drain_idx % ROB_DEPTH`) is filled.
  - `out_last` = `out_valid` && `drain_idx` == `num_lines`−1.
  - On `out_valid`&&`out_ready`: clear the slot and increment `drain_idx`.
- Counters: `issue_idx` and `drain_idx` have width $clog2(LINES_MAX+1). They never wrap within one request.
- Address arithmetic: ADDR width, modulo 2^32.
- Simultaneous events:
  - A return into slot A, a drain of slot B and an issue into slot C may all occur in the same cycle.
  - A freed slot is reusable by an issue only in the next cycle.
  - A return that completes the head slot shows up on `out_valid` in the next cycle, not combinationally.
- Reset (`rst`=0) at any time, including mid-operation:
  - State returns to `IDLE`, all slots are cleared, and both counters are zeroed.
  - Late returns are dropped because no slot is pending.
  - Memory is reset with the block, so stale tags cannot alias.

## Timing
- Reset values: `proc2mem_command`=`MEM_NONE`, `proc2mem_addr`=0, `proc2mem_data`=0, `out_valid`=0, `out_data`=0, `out_last`=0, `busy`=0, `done`=0.
- `start` is sampled in cycle t.
  - The first `MEM_LOAD` can appear in cycle t+1.
  - `busy` rises in t+1.
- Issue throughput: 1 load per cycle.
- Return to `out_valid`: 1 cycle.
- `done` pulses in the cycle after the last beat handshake; `busy` falls in that same cycle.
- `num_lines`=0: `done` pulses at t+1 and no command is issued.
- `proc2mem_*` are combinational from registered state and `bus_grant`. `mem2proc_transaction_tag` is consumed in the same cycle.

## Structure
- Shared types come from `include/sys_defs.svh`: `MEM_COMMAND`, `ADDR`, `MEM_BLOCK`, `MEM_TAG`.
- Add to that same header:
  - `TILE_RD_STATE` enum.
  - `TILE_ROB_ENTRY` struct: pending, filled, tag, data.
- One sub-module, `tile_rob`. It holds the slot array, the tag CAM and the head-slot output mux. The FSM, counters and bus drive stay in `mem_tile_reader`.

## Test plan
- base 0x1000, 8 lines, fixed-latency in-order memory, `out_ready`=1 → loads to 0x1000 through 0x1038, 8 beats in order, `out_last` on beat 8, one `done` pulse.
- 8 lines, bench returns tags in reverse order → output is still in ascending address order and data matches the memory image.
- `mem2proc_transaction_tag`=0 for the first 3 attempts → 0x1000 is driven 4 consecutive cycles, then 0x1008; exactly 8 accepted loads in total.
- 16 lines, ROB_DEPTH 8, `out_ready`=0 → exactly 8 accepted loads, then `MEM_NONE`. Raising `out_ready` resumes issue; 16 beats are delivered.
- Foreign `mem2proc_data_tag` values injected, plus `start` asserted mid-transfer → both ignored, output unchanged. Separately, `num_lines`=0 → `done` at t+1 with no loads.
- `rst` pulsed low after 3 accepted loads → all outputs return to reset values and late returns are dropped. A new `start` at 0x2000 for 4 lines completes correctly.
